// File: rtl/icache_data_arb_pkg.sv
// Shared types for the icache data SRAM arbiter: FSM states and the per-cycle port owner.
package icache_data_arb_pkg;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    SEL_NONE   = 2'd0,
    SEL_FETCH  = 2'd1,
    SEL_REFILL = 2'd2,
    SEL_INIT   = 2'd3
  } arb_sel_e;

endpackage

// File: rtl/icache_data_starve_cnt.sv
// Saturating count of consecutive denied fetch cycles; raises force_fetch_o once the limit is hit.
module icache_data_starve_cnt #(
  parameter int unsigned MaxStarve = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_i,
  input  logic gnt_i,
  output logic force_fetch_o
);

  localparam int unsigned CntWidth = (MaxStarve > 0) ? $clog2(MaxStarve + 1) : 1;
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxStarve);

  logic [CntWidth-1:0] cnt_d, cnt_q;

  // The count never exceeds CntMax, so equality doubles as the saturation test.
  always_comb begin
    cnt_d = cnt_q;
    if (!req_i || gnt_i) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_fetch_o = (MaxStarve != 0) && (cnt_q == CntMax);

endmodule

// File: rtl/icache_data_sram_arb.sv
// Arbiter/sequencer sharing the single-ported icache data SRAM between refill writes and fetch reads.
// Build option ICACHE_DATA_SRAM_INIT_EN zero-fills the array after reset before any grant.
module icache_data_sram_arb
  import icache_data_arb_pkg::*;
#(
  parameter int unsigned NumWords  = 512,
  parameter int unsigned DataWidth = 128,
  parameter int unsigned MaxStarve = 4,
  localparam int unsigned AddrWidth = $clog2(NumWords),
  localparam int unsigned BeWidth   = (DataWidth + 7) / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 fetch_req_i,
  input  logic [AddrWidth-1:0] fetch_addr_i,
  output logic                 fetch_gnt_o,
  output logic                 fetch_rvalid_o,
  output logic [DataWidth-1:0] fetch_rdata_o,
  input  logic                 refill_req_i,
  input  logic [AddrWidth-1:0] refill_addr_i,
  input  logic [DataWidth-1:0] refill_wdata_i,
  input  logic [BeWidth-1:0]   refill_be_i,
  output logic                 refill_gnt_o,
  output logic                 init_done_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic [BeWidth-1:0]   sram_be_o,
  input  logic [DataWidth-1:0] sram_rdata_i
);

`ifdef ICACHE_DATA_SRAM_INIT_EN
  localparam arb_state_e ResetState = INIT;
  logic [AddrWidth-1:0] init_addr_d, init_addr_q;
`else
  localparam arb_state_e ResetState = RUN;
`endif

  arb_state_e           state_d, state_q;
  arb_sel_e             sel;
  logic                 force_fetch;
  logic                 rvalid_d, rvalid_q;
  logic [AddrWidth-1:0] addr_hold_d, addr_hold_q;
  logic [DataWidth-1:0] wdata_hold_d, wdata_hold_q;

  icache_data_starve_cnt #(
    .MaxStarve (MaxStarve)
  ) u_starve_cnt (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .req_i         (fetch_req_i),
    .gnt_i         (fetch_gnt_o),
    .force_fetch_o (force_fetch)
  );

  // Nothing is granted while reset is low; INIT owns the port until the sweep completes.
  always_comb begin
    state_d = state_q;
    sel     = SEL_NONE;
`ifdef ICACHE_DATA_SRAM_INIT_EN
    init_addr_d = init_addr_q;
`endif
    if (!rst_ni) begin
      state_d = ResetState;
    end else if (state_q == RUN) begin
      if (refill_req_i && !(fetch_req_i && force_fetch)) begin
        sel = SEL_REFILL;
      end else if (fetch_req_i) begin
        sel = SEL_FETCH;
      end
    end else begin
`ifdef ICACHE_DATA_SRAM_INIT_EN
      sel         = SEL_INIT;
      init_addr_d = init_addr_q + 1'b1;
      if (&init_addr_q) begin
        state_d = RUN;
      end
`endif
    end
  end

  // Idle cycles replay the last address/data so the SRAM inputs do not toggle needlessly.
  always_comb begin
    sram_addr_o  = addr_hold_q;
    sram_wdata_o = wdata_hold_q;
    sram_be_o    = '0;
    case (sel)
      SEL_FETCH: begin
        sram_addr_o = fetch_addr_i;
      end
      SEL_REFILL: begin
        sram_addr_o  = refill_addr_i;
        sram_wdata_o = refill_wdata_i;
        sram_be_o    = refill_be_i;
      end
`ifdef ICACHE_DATA_SRAM_INIT_EN
      SEL_INIT: begin
        sram_addr_o  = init_addr_q;
        sram_wdata_o = '0;
        sram_be_o    = '1;
      end
`endif
      default: ;
    endcase
  end

  assign fetch_gnt_o    = (sel == SEL_FETCH);
  assign refill_gnt_o   = (sel == SEL_REFILL);
  assign sram_req_o     = (sel != SEL_NONE);
  assign sram_we_o      = (sel == SEL_REFILL) || (sel == SEL_INIT);
  assign init_done_o    = rst_ni && (state_q == RUN);
  assign fetch_rvalid_o = rvalid_q;
  assign fetch_rdata_o  = sram_rdata_i;

  assign rvalid_d     = fetch_gnt_o;
  assign addr_hold_d  = sram_addr_o;
  assign wdata_hold_d = sram_wdata_o;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= ResetState;
      rvalid_q <= 1'b0;
`ifdef ICACHE_DATA_SRAM_INIT_EN
      init_addr_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rvalid_q <= rvalid_d;
`ifdef ICACHE_DATA_SRAM_INIT_EN
      init_addr_q <= init_addr_d;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    addr_hold_q  <= addr_hold_d;
    wdata_hold_q <= wdata_hold_d;
  end

endmodule

// File: tb/tb_icache_data_sram_arb.sv
// Bench for icache_data_sram_arb: directed phases plus random traffic against a behavioural model.
// Follows ICACHE_DATA_SRAM_INIT_EN to know whether an init sweep precedes traffic.
module tb_icache_data_sram_arb;

  localparam int NW = 16;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int BW = 4;
  localparam int MS = 4;
`ifdef ICACHE_DATA_SRAM_INIT_EN
  localparam int INIT_CYCLES = NW;
`else
  localparam int INIT_CYCLES = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fetch_req, refill_req;
  logic [AW-1:0] fetch_addr, refill_addr;
  logic [DW-1:0] refill_wdata;
  logic [BW-1:0] refill_be;
  logic          fetch_gnt, fetch_rvalid, refill_gnt, init_done;
  logic [DW-1:0] fetch_rdata, sram_wdata, sram_rdata;
  logic          sram_req, sram_we;
  logic [AW-1:0] sram_addr;
  logic [BW-1:0] sram_be;

  logic          s_fetch_gnt, s_fetch_rvalid, s_refill_gnt, s_init_done, s_sram_req, s_sram_we;
  logic [DW-1:0] s_fetch_rdata, s_sram_wdata;
  logic [AW-1:0] s_sram_addr;
  logic [BW-1:0] s_sram_be;
  logic [DW-1:0] zero_data = '0;

  always #5 clk = ~clk;

  icache_data_sram_arb #(.NumWords(NW), .DataWidth(DW), .MaxStarve(MS)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr), .fetch_gnt_o(fetch_gnt),
    .fetch_rvalid_o(fetch_rvalid), .fetch_rdata_o(fetch_rdata),
    .refill_req_i(refill_req), .refill_addr_i(refill_addr), .refill_wdata_i(refill_wdata),
    .refill_be_i(refill_be), .refill_gnt_o(refill_gnt), .init_done_o(init_done),
    .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_be_o(sram_be), .sram_rdata_i(sram_rdata)
  );

  // Strict-priority instance sharing the same requests.
  icache_data_sram_arb #(.NumWords(NW), .DataWidth(DW), .MaxStarve(0)) u_strict (
    .clk_i(clk), .rst_ni(rst_n),
    .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr), .fetch_gnt_o(s_fetch_gnt),
    .fetch_rvalid_o(s_fetch_rvalid), .fetch_rdata_o(s_fetch_rdata),
    .refill_req_i(refill_req), .refill_addr_i(refill_addr), .refill_wdata_i(refill_wdata),
    .refill_be_i(refill_be), .refill_gnt_o(s_refill_gnt), .init_done_o(s_init_done),
    .sram_req_o(s_sram_req), .sram_we_o(s_sram_we), .sram_addr_o(s_sram_addr),
    .sram_wdata_o(s_sram_wdata), .sram_be_o(s_sram_be), .sram_rdata_i(zero_data)
  );

  // Single-ported SRAM with byte enables and one-cycle registered read.
  logic [DW-1:0] sram_mem [NW];
  always @(posedge clk) begin
    if (sram_req) begin
      if (sram_we) begin
        for (int b = 0; b < BW; b++)
          if (sram_be[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= sram_mem[sram_addr];
      end
    end
  end

  int checks = 0;
  int errors = 0;

  // Reference model state
  int            init_left;
  int            starve;
  bit            exp_rv;
  bit            s_exp_rv;
  logic [DW-1:0] exp_rd, exp_rm;
  logic [DW-1:0] shadow [NW];
  logic [BW-1:0] shadow_vld [NW];
  int            last_addr;
  bit            prev_fg, prev_rg;
  logic          obs_fg, obs_sfg, obs_rv;
  logic [DW-1:0] obs_rd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] bmask(input logic [BW-1:0] v);
    logic [DW-1:0] m;
    for (int b = 0; b < BW; b++) m[8*b +: 8] = {8{v[b]}};
    return m;
  endfunction

  // One clock: predict, compare at the falling edge, then advance the model past the rising edge.
  task automatic cycle();
    bit            fg, rg, sr, we, sfg, srg, run;
    logic [BW-1:0] be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    @(negedge clk);
    fg = 0; rg = 0; sr = 0; we = 0; be = '0; addr = '0; wd = '0;
    run = rst_n && (init_left == 0);
    if (rst_n && init_left > 0) begin
      sr = 1; we = 1; be = '1; addr = AW'(NW - init_left); wd = '0;
    end else if (run) begin
      fg = fetch_req && (!refill_req || (MS != 0 && starve >= MS));
      rg = refill_req && !fg;
      sr = fg || rg;
      we = rg;
      if (fg) addr = fetch_addr;
      if (rg) begin addr = refill_addr; wd = refill_wdata; be = refill_be; end
    end
    sfg = run && fetch_req && !refill_req;
    srg = run && refill_req;
    obs_fg = fetch_gnt; obs_sfg = s_fetch_gnt; obs_rv = fetch_rvalid; obs_rd = fetch_rdata;

    chk("fetch_gnt", 64'(fetch_gnt), 64'(fg));
    chk("refill_gnt", 64'(refill_gnt), 64'(rg));
    chk("sram_req", 64'(sram_req), 64'(sr));
    chk("sram_we", 64'(sram_we), 64'(we));
    chk("sram_be", 64'(sram_be), 64'(be));
    chk("init_done", 64'(init_done), 64'(run));
    if (sr) chk("sram_addr", 64'(sram_addr), 64'(addr));
    else if (last_addr >= 0) chk("addr_hold", 64'(sram_addr), 64'(last_addr));
    if (we) chk("sram_wdata", 64'(sram_wdata), 64'(wd));
    if (rst_n || !exp_rv) chk("rvalid", 64'(fetch_rvalid), 64'(exp_rv));
    if (rst_n && exp_rv && exp_rm != '0)
      chk("rdata", 64'(fetch_rdata & exp_rm), 64'(exp_rd & exp_rm));
    chk("strict_fetch_gnt", 64'(s_fetch_gnt), 64'(sfg));
    chk("strict_refill_gnt", 64'(s_refill_gnt), 64'(srg));
    chk("strict_sram_req", 64'(s_sram_req), 64'(sfg || srg));
    chk("strict_init_done", 64'(s_init_done), 64'(run));
    if (rst_n || !s_exp_rv) chk("strict_rvalid", 64'(s_fetch_rvalid), 64'(s_exp_rv));

    if (!rst_n) begin
      init_left = INIT_CYCLES; starve = 0; exp_rv = 0; s_exp_rv = 0;
    end else begin
      if (we)
        for (int b = 0; b < BW; b++)
          if (be[b]) begin shadow[addr][8*b +: 8] = wd[8*b +: 8]; shadow_vld[addr][b] = 1'b1; end
      exp_rv = fg;
      s_exp_rv = sfg;
      if (fg) begin exp_rd = shadow[fetch_addr]; exp_rm = bmask(shadow_vld[fetch_addr]); end
      if (fetch_req && !fg) starve = (starve < MS) ? starve + 1 : MS;
      else starve = 0;
      if (init_left > 0) init_left--;
    end
    if (sr) last_addr = int'(addr);
    prev_fg = fg; prev_rg = rg;
    @(posedge clk); #1;
  endtask

  initial begin
    int cnt;
    logic [9:0] pat;
    rst_n = 0; fetch_req = 0; refill_req = 0; fetch_addr = '0; refill_addr = '0;
    refill_wdata = '0; refill_be = '0;
    for (int i = 0; i < NW; i++) begin shadow[i] = '0; shadow_vld[i] = '0; end
    @(posedge clk); @(posedge clk); #1;
    init_left = INIT_CYCLES; starve = 0; exp_rv = 0; s_exp_rv = 0; last_addr = -1;
    prev_fg = 0; prev_rg = 0;

    // Requests during reset must be ignored.
    fetch_req = 1; refill_req = 1; fetch_addr = 4'd3;
    refill_addr = 4'd7; refill_wdata = 32'h1234_5678; refill_be = 4'hF;
    repeat (2) cycle();

    // Release with both requesters already waiting: init sweep, then arbitration.
    rst_n = 1;
    repeat (INIT_CYCLES + 6) cycle();
    fetch_req = 0; refill_req = 0;
    cycle();

    // Write then read the same word on the next cycle.
    refill_req = 1; refill_addr = 4'd5; refill_wdata = 32'hDEAD_BEEF; refill_be = 4'hF;
    cycle();
    refill_req = 0; fetch_req = 1; fetch_addr = 4'd5;
    cycle();
    fetch_req = 0;
    cycle();
    chk("single_read_rvalid", 64'(obs_rv), 64'(1));
    chk("single_read_data", 64'(obs_rd), 64'(32'hDEAD_BEEF));

    // Streaming reads of 0..3 after seeding them.
    for (int i = 0; i < 4; i++) begin
      refill_req = 1; refill_addr = AW'(i); refill_wdata = 32'h1000 + i; refill_be = 4'hF;
      cycle();
    end
    refill_req = 0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      fetch_req = 1; fetch_addr = AW'(i);
      cycle();
      if (i > 0 && obs_rv === 1'b1) cnt++;
    end
    fetch_req = 0;
    cycle();
    if (obs_rv === 1'b1) cnt++;
    chk("stream_rvalid_count", 64'(cnt), 64'(4));
    cycle();

    // Continuous conflict: fetch wins every fifth cycle; strict instance never grants fetch.
    fetch_req = 1; fetch_addr = 4'd1; refill_req = 1; refill_addr = 4'd9;
    refill_wdata = 32'hCAFE_0009; refill_be = 4'hF;
    pat = '0; cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (i < 10) pat = {pat[8:0], obs_fg};
      if (obs_sfg !== 1'b0) cnt++;
    end
    chk("conflict_pattern", 64'(pat), 64'(10'b00001_00001));
    chk("strict_no_fetch", 64'(cnt), 64'(0));
    fetch_req = 0; refill_req = 0;
    cycle();

    // Random traffic; payloads are held until the model says the request was granted.
    for (int n = 0; n < 300; n++) begin
      if (!fetch_req || prev_fg) begin
        fetch_req = 1'($urandom_range(0, 1));
        fetch_addr = AW'($urandom_range(0, NW - 1));
      end
      if (!refill_req || prev_rg) begin
        refill_req = ($urandom_range(0, 2) == 0);
        refill_addr = AW'($urandom_range(0, NW - 1));
        refill_wdata = $urandom;
        refill_be = BW'($urandom_range(1, 15));
      end
      cycle();
    end
    fetch_req = 0; refill_req = 0;
    cycle();

    // Reset in the cycle after a fetch grant drops the response.
    fetch_req = 1; fetch_addr = 4'd2;
    cycle();
    rst_n = 0; refill_req = 1;
    cycle();
    cycle();
    chk("reset_drops_rvalid", 64'(obs_rv), 64'(0));
    rst_n = 1; fetch_req = 0; refill_req = 0;
    repeat (INIT_CYCLES + 2) cycle();
    fetch_req = 1; fetch_addr = 4'd5;
    cycle();
    fetch_req = 0;
    repeat (2) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
